// File: rtl/model_vector_integer_adder_pkg.sv
// Shared constants and FSM state encodings for the vector integer adder.
// The integer constants are sized at their point of use with a width cast.
package model_arithmetic_pkg;

  localparam int ZERO_DATA    = 0;
  localparam int ZERO_CONTROL = 0;
  localparam int ONE_CONTROL  = 1;

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    INPUT_STATE   = 2'd1,
    ENDER_STATE   = 2'd2
  } state_t;

endpackage

// File: rtl/model_vector_integer_adder_if.sv
// Handshake and data bus of the element-serial vector adder.
// The master drives operands and control; the slave (the adder) returns results.
interface model_vector_integer_adder_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
);

  logic                    START;
  logic                    READY;
  logic                    OPERATION;
  logic                    SIGNED_MODE;
  logic [CONTROL_SIZE-1:0] SIZE_IN;
  logic                    DATA_A_IN_ENABLE;
  logic                    DATA_B_IN_ENABLE;
  logic                    DATA_IN_ENABLE;
  logic [DATA_SIZE-1:0]    DATA_A_IN;
  logic [DATA_SIZE-1:0]    DATA_B_IN;
  logic                    DATA_OUT_ENABLE;
  logic [DATA_SIZE-1:0]    DATA_OUT;
  logic                    OVERFLOW_OUT;
  logic                    OVERFLOW_ANY_OUT;

  modport master (
    output START, OPERATION, SIGNED_MODE, SIZE_IN,
    output DATA_A_IN_ENABLE, DATA_B_IN_ENABLE, DATA_A_IN, DATA_B_IN,
    input  READY, DATA_IN_ENABLE, DATA_OUT_ENABLE, DATA_OUT,
    input  OVERFLOW_OUT, OVERFLOW_ANY_OUT
  );

  modport slave (
    input  START, OPERATION, SIGNED_MODE, SIZE_IN,
    input  DATA_A_IN_ENABLE, DATA_B_IN_ENABLE, DATA_A_IN, DATA_B_IN,
    output READY, DATA_IN_ENABLE, DATA_OUT_ENABLE, DATA_OUT,
    output OVERFLOW_OUT, OVERFLOW_ANY_OUT
  );

endinterface

// File: rtl/model_vector_integer_adder_core.sv
// Combinational add/subtract with signed/unsigned overflow detection.
// With MODEL_VECTOR_INTEGER_ADDER_SATURATION_EN defined, overflowing results clamp.
module model_integer_adder_core #(
  parameter int DATA_SIZE = 64
) (
  input  logic [DATA_SIZE-1:0] A,
  input  logic [DATA_SIZE-1:0] B,
  input  logic                 OPERATION,
  input  logic                 SIGNED_MODE,
  output logic [DATA_SIZE-1:0] result,
  output logic                 overflow
);

  localparam int MSB = DATA_SIZE - 1;

  logic [DATA_SIZE:0]   wide;
  logic [DATA_SIZE-1:0] raw;

  // The extra top bit is the carry on add and the borrow on subtract.
  always_comb begin
    if (OPERATION) begin
      wide = {1'b0, A} - {1'b0, B};
    end else begin
      wide = {1'b0, A} + {1'b0, B};
    end
    raw = wide[DATA_SIZE-1:0];
  end

  always_comb begin
    overflow = 1'b0;
    if (SIGNED_MODE) begin
      if (OPERATION) begin
        overflow = (A[MSB] != B[MSB]) && (raw[MSB] != A[MSB]);
      end else begin
        overflow = (A[MSB] == B[MSB]) && (raw[MSB] != A[MSB]);
      end
    end else begin
      overflow = wide[DATA_SIZE];
    end
  end

`ifdef MODEL_VECTOR_INTEGER_ADDER_SATURATION_EN
  // Signed clamps follow the sign of A, which is the sign the true result shares.
  always_comb begin
    result = raw;
    if (overflow) begin
      if (SIGNED_MODE) begin
        result = A[MSB] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
      end else begin
        result = OPERATION ? {DATA_SIZE{1'b0}} : {DATA_SIZE{1'b1}};
      end
    end
  end
`else
  assign result = raw;
`endif

endmodule

// File: rtl/model_vector_integer_adder.sv
// Element-serial vector adder/subtractor: one result per operand pair, READY per vector.
// Saturation instead of wrap is selected by MODEL_VECTOR_INTEGER_ADDER_SATURATION_EN.
module model_vector_integer_adder
  import model_arithmetic_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input logic                         CLK,
  input logic                         RST,
  model_vector_integer_adder_if.slave bus
);

  state_t state;
  state_t next_state;

  logic [CONTROL_SIZE-1:0] index;
  logic [CONTROL_SIZE-1:0] size;
  logic                    operation;
  logic                    signed_mode;
  logic [DATA_SIZE-1:0]    a_data;
  logic [DATA_SIZE-1:0]    b_data;
  logic                    a_got;
  logic                    b_got;
  logic                    both_held;
  logic                    last_element;
  logic                    size_zero;

  logic [DATA_SIZE-1:0]    core_result;
  logic                    core_overflow;

  logic                    data_in_enable;
  logic                    ready;
  logic                    data_out_enable;
  logic [DATA_SIZE-1:0]    data_out;
  logic                    overflow_out;
  logic                    overflow_any;

  // An operand arriving this cycle counts as held, so same-cycle pairs advance at once.
  assign both_held    = (a_got | bus.DATA_A_IN_ENABLE) & (b_got | bus.DATA_B_IN_ENABLE);
  assign last_element = (index == size - CONTROL_SIZE'(ONE_CONTROL));
  assign size_zero    = (bus.SIZE_IN == CONTROL_SIZE'(ZERO_CONTROL));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= STARTER_STATE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      STARTER_STATE: if (bus.START && !size_zero) next_state = INPUT_STATE;
      INPUT_STATE:   if (both_held) next_state = ENDER_STATE;
      ENDER_STATE:   next_state = last_element ? STARTER_STATE : INPUT_STATE;
      default:       next_state = STARTER_STATE;
    endcase
  end

  always_comb begin
    data_in_enable = 1'b0;
    if (state == INPUT_STATE) data_in_enable = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      index       <= CONTROL_SIZE'(ZERO_CONTROL);
      size        <= CONTROL_SIZE'(ZERO_CONTROL);
      operation   <= 1'b0;
      signed_mode <= 1'b0;
      a_data      <= DATA_SIZE'(ZERO_DATA);
      b_data      <= DATA_SIZE'(ZERO_DATA);
      a_got       <= 1'b0;
      b_got       <= 1'b0;
    end else begin
      case (state)
        STARTER_STATE: begin
          if (bus.START) begin
            operation   <= bus.OPERATION;
            signed_mode <= bus.SIGNED_MODE;
            size        <= bus.SIZE_IN;
            index       <= CONTROL_SIZE'(ZERO_CONTROL);
            a_got       <= 1'b0;
            b_got       <= 1'b0;
          end
        end
        INPUT_STATE: begin
          if (bus.DATA_A_IN_ENABLE) begin
            a_data <= bus.DATA_A_IN;
            a_got  <= 1'b1;
          end
          if (bus.DATA_B_IN_ENABLE) begin
            b_data <= bus.DATA_B_IN;
            b_got  <= 1'b1;
          end
        end
        ENDER_STATE: begin
          a_got <= 1'b0;
          b_got <= 1'b0;
          if (!last_element) index <= index + CONTROL_SIZE'(ONE_CONTROL);
        end
        default: begin
          a_got <= 1'b0;
          b_got <= 1'b0;
        end
      endcase
    end
  end

  model_integer_adder_core #(
    .DATA_SIZE(DATA_SIZE)
  ) core (
    .A          (a_data),
    .B          (b_data),
    .OPERATION  (operation),
    .SIGNED_MODE(signed_mode),
    .result     (core_result),
    .overflow   (core_overflow)
  );

  // READY and DATA_OUT_ENABLE are single-cycle pulses; results hold until the next element.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready           <= 1'b0;
      data_out_enable <= 1'b0;
      data_out        <= DATA_SIZE'(ZERO_DATA);
      overflow_out    <= 1'b0;
      overflow_any    <= 1'b0;
    end else begin
      ready           <= 1'b0;
      data_out_enable <= 1'b0;
      case (state)
        STARTER_STATE: begin
          if (bus.START) begin
            overflow_any <= 1'b0;
            if (size_zero) ready <= 1'b1;
          end
        end
        ENDER_STATE: begin
          data_out        <= core_result;
          overflow_out    <= core_overflow;
          data_out_enable <= 1'b1;
          overflow_any    <= overflow_any | core_overflow;
          if (last_element) ready <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.DATA_IN_ENABLE   = data_in_enable;
  assign bus.READY            = ready;
  assign bus.DATA_OUT_ENABLE  = data_out_enable;
  assign bus.DATA_OUT         = data_out;
  assign bus.OVERFLOW_OUT     = overflow_out;
  assign bus.OVERFLOW_ANY_OUT = overflow_any;

endmodule

// File: tb/tb_model_vector_integer_adder.sv
// Directed bench for model_vector_integer_adder at DATA_SIZE=8.
// Expected values adapt to MODEL_VECTOR_INTEGER_ADDER_SATURATION_EN.
module tb_model_vector_integer_adder;

`ifdef MODEL_VECTOR_INTEGER_ADDER_SATURATION_EN
  localparam logic [7:0] EXP_UADD_OVF = 8'hFF;
  localparam logic [7:0] EXP_SSUB_OVF = 8'h80;
  localparam logic [7:0] EXP_SADD_OVF = 8'h7F;
  localparam logic [7:0] EXP_USUB_OVF = 8'h00;
`else
  localparam logic [7:0] EXP_UADD_OVF = 8'd44;
  localparam logic [7:0] EXP_SSUB_OVF = 8'h7F;
  localparam logic [7:0] EXP_SADD_OVF = 8'hC8;
  localparam logic [7:0] EXP_USUB_OVF = 8'hFE;
`endif

  logic clk;
  logic rst;
  int   totalChecks;
  int   badChecks;

  model_vector_integer_adder_if #(.DATA_SIZE(8), .CONTROL_SIZE(4)) bus ();

  model_vector_integer_adder #(
    .DATA_SIZE   (8),
    .CONTROL_SIZE(4)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic startVector(input logic op, input logic sgn, input logic [3:0] size, input string tag);
    bus.START       = 1'b1;
    bus.OPERATION   = op;
    bus.SIGNED_MODE = sgn;
    bus.SIZE_IN     = size;
    stepCycle();
    bus.START = 1'b0;
    checkOutput({tag, "_in_en"}, 64'(bus.DATA_IN_ENABLE), 64'(size != 4'd0));
    checkOutput({tag, "_ready"}, 64'(bus.READY), 64'(size == 4'd0));
    checkOutput({tag, "_any_clr"}, 64'(bus.OVERFLOW_ANY_OUT), 64'd0);
  endtask

  // Drives one element: A first, B bDelay cycles later (0 = same cycle).
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int bDelay,
                               input logic [7:0] expData, input logic expOvf,
                               input logic expReady, input logic expAny, input string tag);
    checkOutput({tag, "_accept"}, 64'(bus.DATA_IN_ENABLE), 64'd1);
    bus.DATA_A_IN        = a;
    bus.DATA_A_IN_ENABLE = 1'b1;
    if (bDelay == 0) begin
      bus.DATA_B_IN        = b;
      bus.DATA_B_IN_ENABLE = 1'b1;
    end
    stepCycle();
    bus.DATA_A_IN_ENABLE = 1'b0;
    bus.DATA_B_IN_ENABLE = 1'b0;
    if (bDelay > 0) begin
      for (int i = 0; i < bDelay - 1; i++) begin
        checkOutput({tag, "_early_out"}, 64'(bus.DATA_OUT_ENABLE), 64'd0);
        checkOutput({tag, "_wait_in_en"}, 64'(bus.DATA_IN_ENABLE), 64'd1);
        stepCycle();
      end
      checkOutput({tag, "_early_out"}, 64'(bus.DATA_OUT_ENABLE), 64'd0);
      bus.DATA_B_IN        = b;
      bus.DATA_B_IN_ENABLE = 1'b1;
      stepCycle();
      bus.DATA_B_IN_ENABLE = 1'b0;
    end
    checkOutput({tag, "_ender_out"}, 64'(bus.DATA_OUT_ENABLE), 64'd0);
    checkOutput({tag, "_ender_in_en"}, 64'(bus.DATA_IN_ENABLE), 64'd0);
    stepCycle();
    checkOutput({tag, "_out_en"}, 64'(bus.DATA_OUT_ENABLE), 64'd1);
    checkOutput({tag, "_data"}, 64'(bus.DATA_OUT), 64'(expData));
    checkOutput({tag, "_ovf"}, 64'(bus.OVERFLOW_OUT), 64'(expOvf));
    checkOutput({tag, "_ready"}, 64'(bus.READY), 64'(expReady));
    if (expReady) checkOutput({tag, "_any"}, 64'(bus.OVERFLOW_ANY_OUT), 64'(expAny));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready_low"}, 64'(bus.READY), 64'd0);
    checkOutput({tag, "_out_low"}, 64'(bus.DATA_OUT_ENABLE), 64'd0);
  endtask

  initial begin
    totalChecks          = 0;
    badChecks            = 0;
    rst                  = 1'b1;
    bus.START            = 1'b0;
    bus.OPERATION        = 1'b0;
    bus.SIGNED_MODE      = 1'b0;
    bus.SIZE_IN          = 4'd0;
    bus.DATA_A_IN_ENABLE = 1'b0;
    bus.DATA_B_IN_ENABLE = 1'b0;
    bus.DATA_A_IN        = 8'd0;
    bus.DATA_B_IN        = 8'd0;
    repeat (2) stepCycle();
    checkOutput("rst_ready", 64'(bus.READY), 64'd0);
    checkOutput("rst_in_en", 64'(bus.DATA_IN_ENABLE), 64'd0);
    checkOutput("rst_out_en", 64'(bus.DATA_OUT_ENABLE), 64'd0);
    checkOutput("rst_data", 64'(bus.DATA_OUT), 64'd0);
    checkOutput("rst_ovf", 64'(bus.OVERFLOW_OUT), 64'd0);
    checkOutput("rst_any", 64'(bus.OVERFLOW_ANY_OUT), 64'd0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] unsigned add, same-cycle operands");
    startVector(1'b0, 1'b0, 4'd3, "uadd_start");
    applyStimulus(8'd1, 8'd2, 0, 8'd3, 1'b0, 1'b0, 1'b0, "uadd_e0");
    applyStimulus(8'd200, 8'd100, 0, EXP_UADD_OVF, 1'b1, 1'b0, 1'b0, "uadd_e1");
    applyStimulus(8'd255, 8'd0, 0, 8'd255, 1'b0, 1'b1, 1'b1, "uadd_e2");
    stepCycle();
    checkIdle("uadd_after");
    checkOutput("uadd_any_held", 64'(bus.OVERFLOW_ANY_OUT), 64'd1);

    $display("[TB] signed sub, B three cycles after A");
    startVector(1'b1, 1'b1, 4'd2, "ssub_start");
    applyStimulus(8'h80, 8'd1, 3, EXP_SSUB_OVF, 1'b1, 1'b0, 1'b0, "ssub_e0");
    applyStimulus(8'd5, 8'd7, 3, 8'hFE, 1'b0, 1'b1, 1'b1, "ssub_e1");
    stepCycle();
    checkIdle("ssub_after");

    $display("[TB] zero-length vector");
    startVector(1'b0, 1'b0, 4'd0, "zero_start");
    checkOutput("zero_out_en", 64'(bus.DATA_OUT_ENABLE), 64'd0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkIdle("zero_after");
      checkOutput("zero_in_en", 64'(bus.DATA_IN_ENABLE), 64'd0);
    end

    $display("[TB] signed add overflow then back-to-back start");
    startVector(1'b0, 1'b1, 4'd1, "sadd_start");
    applyStimulus(8'd100, 8'd100, 0, EXP_SADD_OVF, 1'b1, 1'b1, 1'b1, "sadd_e0");
    startVector(1'b0, 1'b0, 4'd1, "b2b_start");
    applyStimulus(8'd10, 8'd20, 1, 8'd30, 1'b0, 1'b1, 1'b0, "b2b_e0");
    stepCycle();
    checkIdle("b2b_after");

    $display("[TB] unsigned sub borrow");
    startVector(1'b1, 1'b0, 4'd1, "usub_start");
    applyStimulus(8'd3, 8'd5, 0, EXP_USUB_OVF, 1'b1, 1'b1, 1'b1, "usub_e0");
    stepCycle();

    $display("[TB] START ignored mid-vector");
    startVector(1'b0, 1'b0, 4'd2, "ign_start");
    applyStimulus(8'd1, 8'd1, 0, 8'd2, 1'b0, 1'b0, 1'b0, "ign_e0");
    bus.START     = 1'b1;
    bus.OPERATION = 1'b1;
    bus.SIZE_IN   = 4'd5;
    stepCycle();
    bus.START = 1'b0;
    checkOutput("ign_still_input", 64'(bus.DATA_IN_ENABLE), 64'd1);
    applyStimulus(8'd2, 8'd2, 0, 8'd4, 1'b0, 1'b1, 1'b0, "ign_e1");
    stepCycle();
    checkIdle("ign_after");

    $display("[TB] reset mid-vector");
    startVector(1'b0, 1'b0, 4'd4, "abort_start");
    applyStimulus(8'd7, 8'd8, 0, 8'd15, 1'b0, 1'b0, 1'b0, "abort_e0");
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", 64'(bus.READY), 64'd0);
    checkOutput("abort_in_en", 64'(bus.DATA_IN_ENABLE), 64'd0);
    checkOutput("abort_out_en", 64'(bus.DATA_OUT_ENABLE), 64'd0);
    checkOutput("abort_data", 64'(bus.DATA_OUT), 64'd0);
    checkOutput("abort_ovf", 64'(bus.OVERFLOW_OUT), 64'd0);
    checkOutput("abort_any", 64'(bus.OVERFLOW_ANY_OUT), 64'd0);
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkIdle("abort_quiet");
      checkOutput("abort_quiet_in_en", 64'(bus.DATA_IN_ENABLE), 64'd0);
    end
    startVector(1'b0, 1'b0, 4'd4, "fresh_start");
    applyStimulus(8'd1, 8'd1, 0, 8'd2, 1'b0, 1'b0, 1'b0, "fresh_e0");
    applyStimulus(8'd2, 8'd2, 2, 8'd4, 1'b0, 1'b0, 1'b0, "fresh_e1");
    applyStimulus(8'd3, 8'd3, 0, 8'd6, 1'b0, 1'b0, 1'b0, "fresh_e2");
    applyStimulus(8'd4, 8'd4, 0, 8'd8, 1'b0, 1'b1, 1'b0, "fresh_e3");
    stepCycle();
    checkIdle("fresh_after");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/model_vector_integer_adder.md
Name: model_vector_integer_adder

Overview:
- Element-serial vector integer adder/subtractor for the NTM arithmetic library.
- Consumes SIZE_IN operand pairs (A[i], B[i]) over an enable handshake and emits one result per pair.
- Reports overflow per element and per vector, with selectable signed/unsigned arithmetic.
- Building block for vector ops in the controller/memory datapaths: element-wise key differences, weight updates.

Parameters:
- DATA_SIZE, 64, element width in bits.
- CONTROL_SIZE, 4, width of SIZE_IN and of the internal element index.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset. Asynchronous, active-high.
- START  input  1  starts a vector operation; sampled only in STARTER_STATE.
- READY  output  1  one-cycle pulse when the whole vector is done.
- OPERATION  input  1  0 = A+B, 1 = A-B; sampled with START.
- SIGNED_MODE  input  1  1 = two's-complement, 0 = unsigned; sampled with START.
- SIZE_IN  input  CONTROL_SIZE  element count; sampled with START.
- DATA_A_IN_ENABLE  input  1  DATA_A_IN valid this cycle.
- DATA_B_IN_ENABLE  input  1  DATA_B_IN valid this cycle.
- DATA_IN_ENABLE  output  1  high while the block accepts operands for the current element.
- DATA_A_IN  input  DATA_SIZE  operand A element.
- DATA_B_IN  input  DATA_SIZE  operand B element.
- DATA_OUT_ENABLE  output  1  one-cycle pulse, DATA_OUT/OVERFLOW_OUT valid.
- DATA_OUT  output  DATA_SIZE  element result.
- OVERFLOW_OUT  output  1  element overflow, valid with DATA_OUT_ENABLE.
- OVERFLOW_ANY_OUT  output  1  sticky OR of all element overflows; valid with READY, held until next START.

Behaviour:
- Reset, asynchronous on RST=1:
  - Outputs: READY, DATA_IN_ENABLE, DATA_OUT_ENABLE, OVERFLOW_OUT and OVERFLOW_ANY_OUT = 0; DATA_OUT = ZERO_DATA.
  - Internal: index = 0, a_got/b_got = 0, FSM = STARTER_STATE.
  - Reset mid-vector aborts the operation. No READY is issued afterwards.
- STARTER_STATE:
  - READY, DATA_OUT_ENABLE and DATA_IN_ENABLE are 0.
  - On START=1: latch OPERATION, SIGNED_MODE and SIZE_IN; clear OVERFLOW_ANY_OUT; index = 0.
  - If SIZE_IN = 0: pulse READY next cycle, emit no data, stay in STARTER_STATE.
  - Otherwise go to INPUT_STATE.
- INPUT_STATE:
  - DATA_IN_ENABLE = 1.
  - DATA_A_IN is captured on DATA_A_IN_ENABLE and sets a_got; DATA_B_IN is captured on DATA_B_IN_ENABLE and sets b_got.
  - A and B may arrive in the same cycle or in different cycles, in either order.
  - A repeated enable before both operands are present overwrites the held operand.
  - When both operands are held (including same-cycle arrival): go to ENDER_STATE and drop DATA_IN_ENABLE next cycle.
- ENDER_STATE:
  - Register DATA_OUT and OVERFLOW_OUT, pulse DATA_OUT_ENABLE, OR the element overflow into OVERFLOW_ANY_OUT, clear a_got/b_got.
  - If index = size-1: pulse READY in the same cycle and go to STARTER_STATE.
  - Otherwise index++ and return to INPUT_STATE.
- Latency: DATA_OUT_ENABLE comes 2 cycles after the cycle in which the last operand of an element arrives. Maximum throughput is 1 element per 2 cycles.
- START in INPUT_STATE or ENDER_STATE is ignored. Operand enables in STARTER_STATE or ENDER_STATE are ignored.
- Arithmetic is modulo 2^DATA_SIZE. Overflow rules:
  - Unsigned add: carry out of the MSB.
  - Unsigned sub: A < B (borrow).
  - Signed add: A and B have the same sign and the result sign differs.
  - Signed sub: A and B signs differ and the result sign differs from A.
- SIZE_IN = 2^CONTROL_SIZE-1 is the maximum vector length. The index never wraps within a vector.

Optional Feature:
- Macro: MODEL_VECTOR_INTEGER_ADDER_SATURATION_EN.
- Defined: on element overflow, DATA_OUT clamps instead of wrapping:
  - Unsigned add → all ones; unsigned sub → 0.
  - Signed add or sub → max positive if A is non-negative, min negative if A is negative.
- Undefined: results wrap modulo 2^DATA_SIZE.
- OVERFLOW_OUT and OVERFLOW_ANY_OUT behave identically in both builds.

Decomposition:
- model_arithmetic_pkg holds ZERO_DATA, ZERO_CONTROL, ONE_CONTROL and the 2-bit state encodings STARTER_STATE, INPUT_STATE and ENDER_STATE.
- One combinational sub-module, model_integer_adder_core:
  - Inputs: A, B, OPERATION, SIGNED_MODE.
  - Outputs: result and overflow.
  - Holds the saturation logic under the macro.
- The FSM, operand capture and counters stay in the top module.

Test Plan:
- DATA_SIZE=8, unsigned add, SIZE_IN=3, pairs (1,2),(200,100),(255,0) with A and B enabled in the same cycle → DATA_OUT 3,44,255; OVERFLOW_OUT 0,1,0; READY with OVERFLOW_ANY_OUT=1 on the third DATA_OUT_ENABLE.
- DATA_SIZE=8, signed sub, SIZE_IN=2, pairs (-128,1),(5,7), B arriving 3 cycles after A → DATA_OUT 127,254 (-2); OVERFLOW_OUT 1,0; no DATA_OUT_ENABLE before both operands are held.
- Saturation build, DATA_SIZE=8: signed add (100,100) → 127 with OVERFLOW_OUT=1; unsigned sub (3,5) → 0 with OVERFLOW_OUT=1.
- SIZE_IN=0 with START → READY pulse one cycle later; DATA_OUT_ENABLE never asserted; DATA_IN_ENABLE stays 0.
- START re-asserted mid-vector → ignored, element count unchanged. RST=1 after element 1 of 4 → all outputs at reset values immediately; a new START then runs 4 fresh elements.
- Back-to-back: READY then START the next cycle with SIZE_IN=1 → accepted; OVERFLOW_ANY_OUT cleared at the new START.
